// File: rtl/prism_cfg_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prism_cfg_pkg
// Brief    : Shared register map, STATUS layout, FSM encoding and FIFO entry
//            type for the PRISM config sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package prism_cfg_pkg;

    // Host register offsets (byte addresses)
    localparam logic [3:0] REG_LO     = 4'h0;
    localparam logic [3:0] REG_HI     = 4'h4;
    localparam logic [3:0] REG_CTRL   = 4'h8;
    localparam logic [3:0] REG_STATUS = 4'hC;

    // STATUS field positions
    localparam int ST_IDLE_BIT = 0;
    localparam int ST_OVF_BIT  = 1;
    localparam int ST_PERR_BIT = 2;
    localparam int ST_CNT_LSB  = 4;
    localparam int ST_LVL_LSB  = 12;
    localparam int ST_CS_LSB   = 16;

    // Loader offsets: the high word commits the load
    localparam logic [2:0] LD_ADDR_LO = 3'h0;
    localparam logic [2:0] LD_ADDR_HI = 3'h4;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUED    = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic        hi_flag;
        logic [31:0] data;
    } cfg_entry_t;

    // Rotate-left-by-one then fold both halves of the issued word in
    function automatic logic [15:0] cs_next(input logic [15:0] cs, input logic [31:0] d);
        return {cs[14:0], cs[15]} ^ d[15:0] ^ d[31:16];
    endfunction

endpackage
`default_nettype wire

// File: rtl/prism_cfg_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : prism_cfg_if
// Brief    : Host bus + loader side signals of the PRISM config sequencer.
//            slave = sequencer, master = host/loader environment.
// Revision : 1.0 - initial release
// ============================================================================
interface prism_cfg_if;
    logic        bus_wr;
    logic [3:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        ld_write_req;
    logic [2:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ld_busy;

    modport slave (
        input  bus_wr, bus_addr, bus_wdata, ld_busy,
        output bus_rdata, ld_write_req, ld_addr, ld_data
    );

    modport master (
        output bus_wr, bus_addr, bus_wdata, ld_busy,
        input  bus_rdata, ld_write_req, ld_addr, ld_data
    );
endinterface
`default_nettype wire

// File: rtl/prism_cfg_sequencer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : prism_cfg_fifo
// Brief    : Synchronous FIFO of config entries with push/pop/flush and
//            full/empty/level. A push while full is taken only when a pop
//            frees a slot in the same cycle. Flush has priority over push.
// Revision : 1.0 - initial release
// ============================================================================
module prism_cfg_fifo
    import prism_cfg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_push,
    input  wire cfg_entry_t             i_entry,
    input  wire logic                   i_pop,
    input  wire logic                   i_flush,
    output cfg_entry_t                  o_head,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [$clog2(DEPTH):0]      o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    cfg_entry_t      r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [LW-1:0]   r_level;
    logic            w_pop;
    logic            w_push;

    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_head  = r_mem[r_rptr];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    // Pointer and occupancy bookkeeping; flush empties the queue at once
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (!w_push && w_pop) r_level <= r_level - 1'b1;
        end
    end

    // Storage array, no reset needed since empty entries are never read out
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wptr] <= i_entry;
    end
endmodule
`default_nettype wire

// File: rtl/prism_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : prism_cfg_sequencer
// Brief    : Buffers host config writes in a FIFO and replays them to the
//            PRISM latch loader one at a time, never while it is busy.
//            Optional macro PRISM_CFG_CHECKSUM_EN adds a 16-bit running
//            checksum of issued words in STATUS[31:16].
// Revision : 1.0 - initial release
// ============================================================================
module prism_cfg_sequencer
    import prism_cfg_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  wire logic   clk,
    input  wire logic   rst,
    prism_cfg_if.slave  bus
);
    seq_state_t                   r_state;
    seq_state_t                   w_state_nxt;
    logic                         r_ld_write_req;
    logic [2:0]                   r_ld_addr;
    logic [31:0]                  r_ld_data;
    logic                         r_ovf;
    logic                         r_perr;
    logic [CNT_W-1:0]             r_load_cnt;

    logic                         w_wr_lo;
    logic                         w_wr_hi;
    logic                         w_flush;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_cnt_inc;
    logic                         w_perr_set;
    logic                         w_ovf_set;
    cfg_entry_t                   w_entry;
    cfg_entry_t                   w_head;
    logic                         w_full;
    logic                         w_empty;
    logic [$clog2(FIFO_DEPTH):0]  w_level;
    logic [4:0]                   w_lvl5;
    logic [3:0]                   w_lvl4;
    logic [15:0]                  w_cs;
    logic [31:0]                  w_status;

    // Host write decode; flush is a one-cycle strobe, nothing to clear later
    assign w_wr_lo   = bus.bus_wr && (bus.bus_addr == REG_LO);
    assign w_wr_hi   = bus.bus_wr && (bus.bus_addr == REG_HI);
    assign w_flush   = bus.bus_wr && (bus.bus_addr == REG_CTRL) && bus.bus_wdata[0];
    assign w_push    = (w_wr_lo || w_wr_hi) && !w_flush;
    assign w_entry   = '{hi_flag: w_wr_hi, data: bus.bus_wdata};
    assign w_ovf_set = w_push && w_full && !w_pop;

    prism_cfg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and per-cycle actions; a HI word holds off issue until the loader finishes
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_cnt_inc   = 1'b0;
        w_perr_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !bus.ld_busy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUED;
                end
            end
            S_ISSUED: begin
                w_state_nxt = (r_ld_addr == LD_ADDR_HI) ? S_WAIT_BUSY : S_IDLE;
            end
            S_WAIT_BUSY: begin
                if (bus.ld_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else begin
                    w_perr_set  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!bus.ld_busy) begin
                    w_cnt_inc   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Loader outputs: one-cycle pulse, address/data held until next issue
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld_write_req <= 1'b0;
            r_ld_addr      <= 3'h0;
            r_ld_data      <= 32'h0;
        end else begin
            r_ld_write_req <= w_pop;
            if (w_pop) begin
                r_ld_addr <= w_head.hi_flag ? LD_ADDR_HI : LD_ADDR_LO;
                r_ld_data <= w_head.data;
            end
        end
    end

    // Sticky error flags and completed-load counter (counter survives flush)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf      <= 1'b0;
            r_perr     <= 1'b0;
            r_load_cnt <= '0;
        end else begin
            if (w_cnt_inc) r_load_cnt <= r_load_cnt + 1'b1;
            if (w_flush) begin
                r_ovf  <= 1'b0;
                r_perr <= 1'b0;
            end else begin
                if (w_ovf_set)  r_ovf  <= 1'b1;
                if (w_perr_set) r_perr <= 1'b1;
            end
        end
    end

`ifdef PRISM_CFG_CHECKSUM_EN
    logic [15:0] r_cs;

    // Running checksum over every word handed to the loader
    always_ff @(posedge clk) begin
        if (rst || w_flush) r_cs <= 16'h0;
        else if (w_pop)     r_cs <= cs_next(r_cs, w_head.data);
    end
    assign w_cs = r_cs;
`else
    assign w_cs = 16'h0;
`endif

    // Level field saturates at 15 for the 16-deep build
    assign w_lvl5 = 5'(w_level);
    assign w_lvl4 = w_lvl5[4] ? 4'hF : w_lvl5[3:0];

    // STATUS assembly
    always_comb begin
        w_status                          = 32'h0;
        w_status[ST_IDLE_BIT]             = w_empty && (r_state == S_IDLE) && !bus.ld_busy;
        w_status[ST_OVF_BIT]              = r_ovf;
        w_status[ST_PERR_BIT]             = r_perr;
        w_status[ST_CNT_LSB +: 8]         = 8'(r_load_cnt);
        w_status[ST_LVL_LSB +: 4]         = w_lvl4;
        w_status[ST_CS_LSB +: 16]         = w_cs;
    end

    assign bus.bus_rdata    = (bus.bus_addr == REG_STATUS) ? w_status : 32'h0;
    assign bus.ld_write_req = r_ld_write_req;
    assign bus.ld_addr      = r_ld_addr;
    assign bus.ld_data      = r_ld_data;
endmodule
`default_nettype wire

// File: tb/tb_prism_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_prism_cfg_sequencer
// Brief    : Directed self-checking bench for prism_cfg_sequencer with a
//            simple loader model that raises busy after a HI pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prism_cfg_sequencer;
    logic clk;
    logic rst;
    prism_cfg_if bus_if ();

    prism_cfg_sequencer #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          viol = 0;
    int          fall_cyc = 0;
    int          busy_left = 0;
    int          busy_len = 16;
    bit          auto_busy = 1'b0;
    bit          pend_hi = 1'b0;
    logic [2:0]  p_addr [$];
    logic [31:0] p_data [$];
    int          p_cyc  [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: log pulses, then advance the loader model
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus_if.ld_write_req) begin
            if (bus_if.ld_busy) viol++;
            p_addr.push_back(bus_if.ld_addr);
            p_data.push_back(bus_if.ld_data);
            p_cyc.push_back(cyc);
        end
        if (auto_busy) begin
            if (pend_hi) begin
                bus_if.ld_busy = 1'b1;
                busy_left      = busy_len;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    bus_if.ld_busy = 1'b0;
                    fall_cyc       = cyc;
                end
            end
        end
        pend_hi = bus_if.ld_write_req && (bus_if.ld_addr == 3'h4);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus_if.bus_wr    = 1'b1;
        bus_if.bus_addr  = a;
        bus_if.bus_wdata = d;
        tick();
        bus_if.bus_wr    = 1'b0;
    endtask

    task automatic rd(output logic [31:0] v);
        bus_if.bus_addr = 4'hC;
        #1;
        v = bus_if.bus_rdata;
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] s;
        s = 32'h0;
        for (int i = 0; i < 300; i++) begin
            rd(s);
            if (s[0]) break;
            tick();
        end
        chk(tag, {31'h0, s[0]}, 32'h1);
    endtask

    logic [31:0] st;
    int          base;
    int          rel;

    initial begin
        rst              = 1'b1;
        bus_if.bus_wr    = 1'b0;
        bus_if.bus_addr  = 4'h0;
        bus_if.bus_wdata = 32'h0;
        bus_if.ld_busy   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_req",  {31'h0, bus_if.ld_write_req}, 32'h0);
        chk("rst_addr", {29'h0, bus_if.ld_addr}, 32'h0);
        chk("rst_data", bus_if.ld_data, 32'h0);
        #1;
        chk("rst_rdata_off0", bus_if.bus_rdata, 32'h0);
        rd(st);
        chk("rst_status", st, 32'h0000_0001);

        // LO + HI pair, latency and load count
        auto_busy = 1'b1;
        busy_len  = 16;
        base      = p_cyc.size();
        wr(4'h0, 32'hDEAD_BEEF);
        rel = cyc;
        wr(4'h4, 32'h0000_00A5);
        wait_idle("s1_idle");
        chk("s1_npulse", p_cyc.size(), base + 2);
        if (p_cyc.size() == base + 2) begin
            chk("s1_p0_addr", {29'h0, p_addr[base]}, 32'h0);
            chk("s1_p0_data", p_data[base], 32'hDEAD_BEEF);
            chk("s1_p0_lat",  p_cyc[base], rel + 1);
            chk("s1_p1_addr", {29'h0, p_addr[base+1]}, 32'h4);
            chk("s1_p1_data", p_data[base+1], 32'h0000_00A5);
            chk("s1_p1_lat",  p_cyc[base+1], rel + 3);
        end
        rd(st);
        chk("s1_status", st, 32'h0000_0011);
        chk("s1_data_hold", bus_if.ld_data, 32'h0000_00A5);

        // Overflow with busy held high
        auto_busy      = 1'b0;
        bus_if.ld_busy = 1'b1;
        base           = p_cyc.size();
        for (int i = 1; i <= 5; i++) wr(4'h0, i);
        rd(st);
        chk("s2_ovf_status", st, 32'h0000_4012);
        chk("s2_no_pulse", p_cyc.size(), base);
        bus_if.ld_busy = 1'b0;
        rel            = cyc;
        wait_idle("s2_idle");
        chk("s2_npulse", p_cyc.size(), base + 4);
        if (p_cyc.size() == base + 4) begin
            chk("s2_first_after_release", p_cyc[base], rel + 1);
            chk("s2_last_data", p_data[base+3], 32'h4);
            chk("s2_lo_spacing", p_cyc[base+3] - p_cyc[base], 6);
        end
        rd(st);
        chk("s2_status", st, 32'h0000_0013);

        // HI holds off a queued LO until the 16-cycle busy window ends
        auto_busy = 1'b1;
        viol      = 0;
        base      = p_cyc.size();
        wr(4'h4, 32'h0000_0011);
        wr(4'h0, 32'h0000_0022);
        wait_idle("s3_idle");
        chk("s3_viol", viol, 0);
        chk("s3_npulse", p_cyc.size(), base + 2);
        if (p_cyc.size() == base + 2) begin
            chk("s3_lo_data", p_data[base+1], 32'h0000_0022);
            chk("s3_lo_after_fall", p_cyc[base+1], fall_cyc + 2);
        end
        rd(st);
        chk("s3_status", st, 32'h0000_0023);

        // HI with busy never rising -> protocol error, no count
        auto_busy      = 1'b0;
        bus_if.ld_busy = 1'b0;
        wr(4'h4, 32'h0000_0033);
        wait_idle("s4_idle");
        rd(st);
        chk("s4_status", st, 32'h0000_0027);

        // Flush with three entries queued behind an in-flight HI
        auto_busy = 1'b1;
        base      = p_cyc.size();
        wr(4'h4, 32'h0000_0044);
        wr(4'h0, 32'h1);
        wr(4'h0, 32'h2);
        wr(4'h0, 32'h3);
        rd(st);
        chk("s5_pre_flush", st, 32'h0000_3026);
        wr(4'h8, 32'h1);
        rd(st);
        chk("s5_post_flush", st, 32'h0000_0020);
        wait_idle("s5_idle");
        rd(st);
        chk("s5_status", st, 32'h0000_0031);
        chk("s5_npulse", p_cyc.size(), base + 1);

        // Writes to STATUS and unmapped offsets are ignored
        base = p_cyc.size();
        wr(4'hC, 32'hFFFF_FFFF);
        wr(4'h2, 32'h1234_5678);
        tick();
        tick();
        rd(st);
        chk("s6_ignored_status", st, 32'h0000_0031);
        chk("s6_ignored_pulse", p_cyc.size(), base);

        // Checksum field
        wr(4'h0, 32'h0001_0002);
        wr(4'h4, 32'h0000_0004);
        wait_idle("s7_idle");
        rd(st);
`ifdef PRISM_CFG_CHECKSUM_EN
        chk("s7_cs", {16'h0, st[31:16]}, 32'h0000_0002);
`else
        chk("s7_cs_off", {16'h0, st[31:16]}, 32'h0);
`endif
        chk("s7_cnt", {24'h0, st[11:4]}, 32'h4);
        wr(4'h8, 32'h1);
        rd(st);
        chk("s7_cs_flush", {16'h0, st[31:16]}, 32'h0);

        // Reset in the middle of a load
        wr(4'h4, 32'h0000_0055);
        repeat (5) tick();
        rst            = 1'b1;
        auto_busy      = 1'b0;
        bus_if.ld_busy = 1'b0;
        busy_left      = 0;
        tick();
        rst = 1'b0;
        tick();
        rd(st);
        chk("s8_rst_status", st, 32'h0000_0001);
        chk("s8_rst_req", {31'h0, bus_if.ld_write_req}, 32'h0);
        chk("s8_rst_data", bus_if.ld_data, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
